lif_neuron_bank: RTL

Parametrised bank of CHANNELS leaky integrate-and-fire neurons. All channels update in parallel on a `step` strobe.
- Adds over the single-neuron block: runtime-configurable threshold, selectable post-spike reset mode, refractory period, saturating arithmetic, and an aggregate spike counter.
- Sits between the input current bus (pad inputs or an upstream synapse stage) and the spike/state observation outputs.

---
 rtl/lif_pkg.sv | 33 +++
 rtl/lif_channel.sv | 67 ++++++
 rtl/lif_neuron_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared constants, default parameters and saturating add for
//                the LIF neuron bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    localparam logic LIF_MODE_ZERO = 1'b0;
    localparam logic LIF_MODE_SUB  = 1'b1;

    localparam int c_DEF_CHANNELS   = 4;
    localparam int c_DEF_IN_W       = 6;
    localparam int c_DEF_STATE_W    = 8;
    localparam int c_DEF_LEAK_SHIFT = 1;
    localparam int c_DEF_REFRAC_W   = 3;
    localparam int c_DEF_THRESHOLD  = 32;
    localparam int c_DEF_CNT_W      = 16;

    // Unsigned add clamped to 2^w-1; w must be at most 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_channel.sv
`default_nettype none
// ============================================================================
//  Module      : lif_channel
//  Description : One leaky integrate-and-fire neuron with refractory counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_channel
    import lif_pkg::*;
#(
    parameter int IN_W       = c_DEF_IN_W,
    parameter int STATE_W    = c_DEF_STATE_W,
    parameter int LEAK_SHIFT = c_DEF_LEAK_SHIFT,
    parameter int REFRAC_W   = c_DEF_REFRAC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [IN_W-1:0]     in_current,
    input  logic [STATE_W-1:0]  threshold,
    input  logic [REFRAC_W-1:0] refractory,
    input  logic                mode,
    output logic                fire,
    output logic                spike,
    output logic [STATE_W-1:0]  state
);

    localparam logic [REFRAC_W-1:0] c_RCNT_ONE = REFRAC_W'(1);

    logic [STATE_W-1:0]  r_state;
    logic [REFRAC_W-1:0] r_rcnt;
    logic                r_spike;
    logic [STATE_W-1:0]  w_leaked;
    logic [STATE_W-1:0]  w_sum;
    logic                w_fire;

    assign w_leaked = r_state - (r_state >> LEAK_SHIFT);
    assign w_sum    = STATE_W'(sat_add(32'(w_leaked), 32'(in_current), STATE_W));
    // Only a real, non-refractory step can fire; this also feeds the bank counter.
    assign w_fire   = step && (r_rcnt == '0) && (threshold != '0) && (w_sum >= threshold);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_rcnt  <= '0;
            r_spike <= 1'b0;
        end else if (!step) begin
            r_spike <= 1'b0;
        end else if (r_rcnt != '0) begin
            r_rcnt  <= r_rcnt - c_RCNT_ONE;
            r_state <= '0;
            r_spike <= 1'b0;
        end else if (w_fire) begin
            r_spike <= 1'b1;
            r_state <= (mode == LIF_MODE_SUB) ? (w_sum - threshold) : '0;
            r_rcnt  <= refractory;
        end else begin
            r_spike <= 1'b0;
            r_state <= w_sum;
        end
    end

    assign fire  = w_fire;
    assign spike = r_spike;
    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/lif_neuron_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_bank
//  Description : Bank of CHANNELS LIF neurons with shared configuration,
//                state readout mux and saturating aggregate spike counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_bank
    import lif_pkg::*;
#(
    parameter int CHANNELS      = c_DEF_CHANNELS,
    parameter int IN_W          = c_DEF_IN_W,
    parameter int STATE_W       = c_DEF_STATE_W,
    parameter int LEAK_SHIFT    = c_DEF_LEAK_SHIFT,
    parameter int REFRAC_W      = c_DEF_REFRAC_W,
    parameter int DEF_THRESHOLD = c_DEF_THRESHOLD,
    parameter int CNT_W         = c_DEF_CNT_W,
    localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic [CHANNELS*IN_W-1:0] in_current,
    input  logic                     cfg_we,
    input  logic [STATE_W-1:0]       cfg_threshold,
    input  logic [REFRAC_W-1:0]      cfg_refractory,
    input  logic                     cfg_mode,
    input  logic                     count_clr,
    input  logic [SEL_W-1:0]         state_sel,
    output logic [CHANNELS-1:0]      spike,
    output logic [STATE_W-1:0]       state_out,
    output logic [CNT_W-1:0]         spike_count
);

    logic [STATE_W-1:0]  r_threshold;
    logic [REFRAC_W-1:0] r_refractory;
    logic                r_mode;
    logic [CNT_W-1:0]    r_count;

    logic [CHANNELS-1:0] w_fire;
    logic [STATE_W-1:0]  w_state [CHANNELS];
    logic [31:0]         w_pop;
    logic [CNT_W-1:0]    w_base;
    logic [STATE_W-1:0]  w_state_out;

    // Config registers update at the edge, so a coincident step sees the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_threshold  <= STATE_W'(DEF_THRESHOLD);
            r_refractory <= '0;
            r_mode       <= LIF_MODE_ZERO;
        end else if (cfg_we) begin
            r_threshold  <= cfg_threshold;
            r_refractory <= cfg_refractory;
            r_mode       <= cfg_mode;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_channel
            lif_channel #(
                .IN_W       (IN_W),
                .STATE_W    (STATE_W),
                .LEAK_SHIFT (LEAK_SHIFT),
                .REFRAC_W   (REFRAC_W)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .step       (step),
                .in_current (in_current[g*IN_W +: IN_W]),
                .threshold  (r_threshold),
                .refractory (r_refractory),
                .mode       (r_mode),
                .fire       (w_fire[g]),
                .spike      (spike[g]),
                .state      (w_state[g])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_pop = w_pop + 32'(w_fire[c]);
        end
    end

    // Clear-then-add: a coincident clear and step leaves only this step's spikes.
    assign w_base = count_clr ? '0 : r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= CNT_W'(sat_add(32'(w_base), w_pop, CNT_W));
        end
    end

    always_comb begin
        w_state_out = '0;
        if (32'(state_sel) < CHANNELS) begin
            w_state_out = w_state[state_sel];
        end
    end

    assign state_out   = w_state_out;
    assign spike_count = r_count;

endmodule
`default_nettype wire
